// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC owner: issues instruction-memory requests, absorbs write-back redirects
// (including ones that land mid-fetch), buffers a word across decode stalls, and freezes on HALT.
module fetch_pc_ctrl #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] new_PC,
    input  logic        redirect,
    input  logic        stall,
    input  logic        halt,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        imem_en,
    output logic [15:0] imem_addr,
    output logic [15:0] instr,
    output logic [15:0] PC2,
    output logic        if_valid,
    output logic        halted,
    output logic        misalign
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_BUF    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] pend_pc_r, pend_pc_s;
    logic        pend_vld_r, pend_vld_s;
    logic [15:0] buf_r, buf_s;
    logic [15:0] instr_r, instr_s;
    logic [15:0] pc2_r, pc2_s;
    logic        if_valid_r, if_valid_s;
    logic        halted_r, halted_s;
    logic        misalign_r, misalign_s;

    logic [15:0] target_s;
    logic [15:0] pc_inc_s;

    assign target_s = {new_PC[15:1], 1'b0};
    assign pc_inc_s = pc_r + 16'd2;

    // Next-state logic; any redirect flushes the word held for decode
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        pend_pc_s  = pend_pc_r;
        pend_vld_s = pend_vld_r;
        buf_s      = buf_r;
        instr_s    = instr_r;
        pc2_s      = pc2_r;
        if_valid_s = if_valid_r;
        halted_s   = halted_r;
        misalign_s = misalign_r;

        if (halt && (state_r != ST_HALTED)) begin
            state_s    = ST_HALTED;
            halted_s   = 1'b1;
            if_valid_s = 1'b0;
            instr_s    = NOP_INSTR;
            pend_vld_s = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (redirect) begin
                        misalign_s = misalign_r | new_PC[0];
                        if_valid_s = 1'b0;
                        instr_s    = NOP_INSTR;
                        if (imem_rdy) begin
                            pc_s       = target_s;
                            pend_vld_s = 1'b0;
                        end else begin
                            pend_pc_s  = target_s;
                            pend_vld_s = 1'b1;
                        end
                    end else if (pend_vld_r) begin
                        if_valid_s = 1'b0;
                        instr_s    = NOP_INSTR;
                        if (imem_rdy) begin
                            pc_s       = pend_pc_r;
                            pend_vld_s = 1'b0;
                        end else begin
                            pend_vld_s = 1'b1;
                        end
                    end else if (imem_rdy) begin
                        if (stall) begin
                            buf_s   = imem_data;
                            state_s = ST_BUF;
                        end else begin
                            instr_s    = imem_data;
                            pc2_s      = pc_inc_s;
                            if_valid_s = 1'b1;
                            pc_s       = pc_inc_s;
                        end
                    end else if (!stall) begin
                        if_valid_s = 1'b0;
                        instr_s    = NOP_INSTR;
                    end else begin
                        if_valid_s = if_valid_r;
                    end
                end
                ST_BUF: begin
                    if (redirect) begin
                        misalign_s = misalign_r | new_PC[0];
                        pc_s       = target_s;
                        if_valid_s = 1'b0;
                        instr_s    = NOP_INSTR;
                        pend_vld_s = 1'b0;
                        state_s    = ST_FETCH;
                    end else if (!stall) begin
                        instr_s    = buf_r;
                        pc2_s      = pc_inc_s;
                        if_valid_s = 1'b1;
                        pc_s       = pc_inc_s;
                        state_s    = ST_FETCH;
                    end else begin
                        state_s = ST_BUF;
                    end
                end
                ST_HALTED: begin
                    halted_s   = 1'b1;
                    if_valid_s = 1'b0;
                    instr_s    = NOP_INSTR;
                end
                default: begin
                    state_s    = ST_FETCH;
                    if_valid_s = 1'b0;
                    instr_s    = NOP_INSTR;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            pend_pc_r  <= RESET_PC;
            pend_vld_r <= 1'b0;
            buf_r      <= NOP_INSTR;
            instr_r    <= NOP_INSTR;
            pc2_r      <= RESET_PC + 16'd2;
            if_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pend_pc_r  <= pend_pc_s;
            pend_vld_r <= pend_vld_s;
            buf_r      <= buf_s;
            instr_r    <= instr_s;
            pc2_r      <= pc2_s;
            if_valid_r <= if_valid_s;
            halted_r   <= halted_s;
            misalign_r <= misalign_s;
        end
    end

    // Request side depends only on state and PC so the address is stable until imem_rdy
    assign imem_en   = (state_r == ST_FETCH);
    assign imem_addr = pc_r;
    assign instr     = instr_r;
    assign PC2       = pc2_r;
    assign if_valid  = if_valid_r;
    assign halted    = halted_r;
    assign misalign  = misalign_r;

endmodule
